ula_arb: RTL

ULA_ARB -- requirements
Module: ula_arb

---
 rtl/ula_arb.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ula_arb.sv
// ula_arb: two-requester round-robin front end for one shared 4-bit ALU.
// Each operation takes IDLE -> EXEC (grant pulse) -> DONE (done pulse), so
// peak throughput is one operation every three cycles.
// Optional feature: define ULA_ARB_FLAGS_EN to add registered zero/carry
// flags (flag_z, flag_c) that update together with result.

// Team 4-bit ALU, purely combinational.
module ula (
   input  logic [2:0] op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);
   // Selector decode; 110/111 are unused codes and return zero.
   always_comb begin
      y = 4'b0000;
      case (op)
         3'b000:  y = a & b;
         3'b001:  y = a | b;
         3'b010:  y = ~a;
         3'b011:  y = ~(a & b);
         3'b100:  y = a + b;
         3'b101:  y = a - b;
         default: y = 4'b0000;
      endcase
   end
endmodule

module ula_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [2:0] op0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic       req1,
   input  logic [2:0] op1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] result,
   output logic       busy
`ifdef ULA_ARB_FLAGS_EN
   ,
   output logic       flag_z,
   output logic       flag_c
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t     state, state_d;
   logic       cap;        // capture winner's operands this edge
   logic       pick;       // winner of the current arbitration (1 = req1)
   logic       win;        // requester owning the in-flight operation
   logic       last;       // last requester served (1 = req1)
   logic [2:0] op_r;
   logic [3:0] a_r, b_r;
   logic [3:0] alu_y;

   // Lone requester always wins; on a tie the one not served last wins.
   assign pick = (req0 && req1) ? ~last : req1;

   assign busy = (state != IDLE);

   // The ALU only ever sees the captured operands, so requester inputs may
   // change freely once the grant has been given.
   ula u_ula (
      .op (op_r),
      .a  (a_r),
      .b  (b_r),
      .y  (alu_y)
   );

   // Next-state logic; requests are only looked at in IDLE.
   always_comb begin
      state_d = state;
      cap     = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               cap     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Operand capture; no reset needed since these are only consumed after a capture.
   always_ff @(posedge clk) begin
      if (cap) begin
         win  <= pick;
         op_r <= pick ? op1 : op0;
         a_r  <= pick ? a1  : a0;
         b_r  <= pick ? b1  : b0;
      end
   end

   // Registered handshake pulses, result and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         result <= 4'b0000;
         last   <= 1'b1;
      end else begin
         gnt0  <= cap && !pick;
         gnt1  <= cap &&  pick;
         done0 <= (state == EXEC) && !win;
         done1 <= (state == EXEC) &&  win;
         if (state == EXEC) result <= alu_y;
         if (state == DONE) last   <= win;
      end
   end

`ifdef ULA_ARB_FLAGS_EN
   logic [4:0] sum5;
   logic       carry;

   // Carry for ADD, borrow for SUB, zero for everything else.
   always_comb begin
      sum5  = {1'b0, a_r} + {1'b0, b_r};
      carry = 1'b0;
      if (op_r == 3'b100)      carry = sum5[4];
      else if (op_r == 3'b101) carry = (a_r < b_r);
   end

   // Flags update on the same edge as result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else if (state == EXEC) begin
         flag_z <= (alu_y == 4'b0000);
         flag_c <= carry;
      end
   end
`endif

endmodule
